// File: rtl/dot_operand_feeder_pkg.sv
// Shared types and constants for the dot-product operand feeder.
// The FSM state enum and beat-count helpers are used by the top and the packer.
package dot_operand_feeder_pkg;

   typedef enum logic [2:0] {
      StLoadW,
      StLoadA,
      StFire,
      StWait,
      StOut
   } state_e;

   localparam int unsigned DefN             = 128;
   localparam int unsigned DefWeightWidth   = 4;
   localparam int unsigned DefActWidth      = 4;
   localparam int unsigned DefBusWidth      = 32;
   localparam int unsigned DefResultWidth   = 16;
   localparam int unsigned DefTimeoutCycles = 64;

   function automatic int unsigned beat_count(input int unsigned n, input int unsigned width,
                                              input int unsigned bus);
      return (n * width) / bus;
   endfunction

   localparam int unsigned WB = beat_count(DefN, DefWeightWidth, DefBusWidth);
   localparam int unsigned AB = beat_count(DefN, DefActWidth, DefBusWidth);

endpackage

// File: rtl/dot_operand_feeder_beat_packer.sv
// Assembles a wide operand vector from narrow beats: beat k lands in slice k.
// The counter wraps to 0 after the last beat, so the packer is ready for the next job.
module dot_operand_feeder_beat_packer
   import dot_operand_feeder_pkg::*;
#(
   parameter int unsigned Beats    = 16,
   parameter int unsigned BusWidth = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [BusWidth-1:0]       data,
   output logic [Beats*BusWidth-1:0] vec,
   output logic                      empty,
   output logic                      full
);

   localparam int unsigned CntW = (Beats > 1) ? $clog2(Beats) : 1;

   logic [CntW-1:0]           cnt_q;
   logic [Beats*BusWidth-1:0] vec_q;
   logic                      last;

   assign last = (cnt_q == CntW'(Beats - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         vec_q <= '0;
      end else if (en) begin
         vec_q[cnt_q * BusWidth +: BusWidth] <= data;
         cnt_q <= last ? '0 : cnt_q + 1'b1;
      end
   end

   assign vec   = vec_q;
   assign empty = (cnt_q == '0);
   // Pulses while the final beat is being accepted.
   assign full  = en && last;

endmodule

// File: rtl/dot_operand_feeder.sv
// Operand/start sequencer for the dot-product engine: load weights, load acts, fire, wait, return.
// Optional WAIT timeout is enabled by defining DOT_FEEDER_TIMEOUT_EN.
module dot_operand_feeder
   import dot_operand_feeder_pkg::*;
#(
   parameter int unsigned N              = DefN,
   parameter int unsigned WEIGHT_WIDTH   = DefWeightWidth,
   parameter int unsigned ACT_WIDTH      = DefActWidth,
   parameter int unsigned BUS_WIDTH      = DefBusWidth,
`ifdef DOT_FEEDER_TIMEOUT_EN
   parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles,
`endif
   parameter int unsigned RESULT_WIDTH   = DefResultWidth
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [BUS_WIDTH-1:0]        s_data,
   output logic                        o_start,
   output logic [N*WEIGHT_WIDTH-1:0]   o_weights_flat,
   output logic [N*ACT_WIDTH-1:0]      o_acts_flat,
   input  logic                        i_done,
   input  logic [RESULT_WIDTH-1:0]     i_result,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [RESULT_WIDTH-1:0]     m_data,
   output logic                        m_err,
   output logic                        busy
);

   localparam int unsigned WBeats = beat_count(N, WEIGHT_WIDTH, BUS_WIDTH);
   localparam int unsigned ABeats = beat_count(N, ACT_WIDTH, BUS_WIDTH);

   state_e                  state_q, state_d;
   logic                    w_en, a_en;
   logic                    w_full, a_full;
   logic                    w_empty, a_empty;
   logic                    tmo_expired;
   logic [RESULT_WIDTH-1:0] m_data_q;

   assign w_en = s_valid && s_ready && (state_q == StLoadW);
   assign a_en = s_valid && s_ready && (state_q == StLoadA);

   dot_operand_feeder_beat_packer #(
      .Beats    (WBeats),
      .BusWidth (BUS_WIDTH)
   ) u_weight_packer (
      .clk   (clk),
      .rst   (rst),
      .en    (w_en),
      .data  (s_data),
      .vec   (o_weights_flat),
      .empty (w_empty),
      .full  (w_full)
   );

   dot_operand_feeder_beat_packer #(
      .Beats    (ABeats),
      .BusWidth (BUS_WIDTH)
   ) u_act_packer (
      .clk   (clk),
      .rst   (rst),
      .en    (a_en),
      .data  (s_data),
      .vec   (o_acts_flat),
      .empty (a_empty),
      .full  (a_full)
   );

`ifdef DOT_FEEDER_TIMEOUT_EN
   localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TmoW-1:0] tmo_q;
   logic            m_err_q;

   assign tmo_expired = (state_q == StWait) && (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst || (state_q != StWait)) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_q + 1'b1;
      end
   end

   // A done arriving on the expiry cycle still wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         m_err_q <= 1'b0;
      end else if ((state_q == StWait) && i_done) begin
         m_err_q <= 1'b0;
      end else if (tmo_expired) begin
         m_err_q <= 1'b1;
      end
   end

   assign m_err = m_err_q;
`else
   assign tmo_expired = 1'b0;
   assign m_err       = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         m_data_q <= '0;
      end else if ((state_q == StWait) && i_done) begin
         m_data_q <= i_result;
      end else if (tmo_expired) begin
         m_data_q <= '0;
      end
   end

   assign m_data = m_data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StLoadW;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StLoadW: if (w_full) state_d = StLoadA;
         StLoadA: if (a_full) state_d = StFire;
         StFire:  state_d = StWait;
         StWait:  if (i_done || tmo_expired) state_d = StOut;
         StOut:   if (m_ready) state_d = StLoadW;
         default: state_d = StLoadW;
      endcase
   end

   always_comb begin
      s_ready = 1'b0;
      o_start = 1'b0;
      m_valid = 1'b0;
      busy    = 1'b1;
      unique case (state_q)
         StLoadW: begin
            s_ready = 1'b1;
            // The act counter has always wrapped back to 0 by the time LOAD_W is entered.
            busy    = !(w_empty && a_empty);
         end
         StLoadA: s_ready = 1'b1;
         StFire:  o_start = 1'b1;
         StWait:  ;
         StOut:   m_valid = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dot_operand_feeder.sv
// Self-checking bench for dot_operand_feeder with a behavioural 8-cycle dot-product engine.
// Table-driven jobs plus hand-written hold, reset and (optional) timeout sequences.
module tb_dot_operand_feeder;

   localparam int unsigned Wb = 16;
   localparam int unsigned Ab = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [31:0]   s_data = '0;
   logic          o_start;
   logic [511:0]  o_weights_flat;
   logic [511:0]  o_acts_flat;
   logic          i_done = 1'b0;
   logic [15:0]   i_result = '0;
   logic          m_valid;
   logic          m_ready = 1'b1;
   logic [15:0]   m_data;
   logic          m_err;
   logic          busy;

   always #5 clk = ~clk;

   dot_operand_feeder dut (
      .clk            (clk),
      .rst            (rst),
      .s_valid        (s_valid),
      .s_ready        (s_ready),
      .s_data         (s_data),
      .o_start        (o_start),
      .o_weights_flat (o_weights_flat),
      .o_acts_flat    (o_acts_flat),
      .i_done         (i_done),
      .i_result       (i_result),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_data         (m_data),
      .m_err          (m_err),
      .busy           (busy)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] dot_model(input logic [511:0] w, input logic [511:0] a);
      int s = 0;
      for (int i = 0; i < 128; i++) s += $signed(w[i*4 +: 4]) * $signed(a[i*4 +: 4]);
      return s[15:0];
   endfunction

   typedef struct packed {
      logic [15:0] d;
      logic        e;
   } exp_t;

   exp_t sb[$];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Engine model: result 8 cycles after the start pulse; stray dones on request.
   int          eng_cnt = 0;
   logic [15:0] eng_res = '0;
   bit          eng_enable = 1'b1;
   int          stray_cnt = 0;
   int          stray_ack = 0;
   logic        real_done = 1'b0;

   always @(negedge clk) begin
      i_done = 1'b0;
      real_done = 1'b0;
      if (eng_cnt != 0) begin
         eng_cnt--;
         if (eng_cnt == 0 && eng_enable) begin
            i_done = 1'b1;
            i_result = eng_res;
            real_done = 1'b1;
         end
      end else if (stray_cnt != stray_ack) begin
         i_done = 1'b1;
         i_result = 16'hDEAD;
         stray_ack++;
      end
      if (o_start) begin
         eng_res = dot_model(o_weights_flat, o_acts_flat);
         eng_cnt = 8;
      end
   end

   // Monitor: sampled 2 time units after the negedge, well away from posedge.
   logic prev_start = 1'b0;
   logic prev_real_done = 1'b0;
   int   start_cyc[$];

   always @(negedge clk) begin
      exp_t e;
      #2;
      if (prev_start) check("start_width", o_start, 0);
      if (o_start && !prev_start) start_cyc.push_back(cyc);
      if (prev_real_done) check("valid_after_done", m_valid, 1);
      if (m_valid && m_ready) begin
         check("result_expected", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("result_data", m_data, e.d);
            check("result_err", m_err, e.e);
         end
      end
      prev_start = o_start;
      prev_real_done = real_done;
   end

   task automatic send_beat(input logic [31:0] d, input bit gap);
      int t;
      if (gap) begin
         s_valid = 1'b0;
         @(negedge clk);
      end
      s_valid = 1'b1;
      s_data = d;
      t = 0;
      while (!s_ready && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready) check("s_ready_wait", s_ready, 1);
      @(negedge clk);
      s_valid = 1'b0;
   endtask

   task automatic run_job(input logic [511:0] w, input logic [511:0] a, input bit gaps);
      for (int k = 0; k < Wb; k++) begin
         send_beat(w[k*32 +: 32], gaps && (k % 3 == 1));
         if (k == 0) check("busy_after_beat", busy, 1);
      end
      for (int k = 0; k < Ab; k++) send_beat(a[k*32 +: 32], gaps && (k % 4 == 2));
      check("start_after_last_beat", o_start, 1);
      check("valid_low_at_start", m_valid, 0);
   endtask

   task automatic drain(input string name);
      int t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      check(name, sb.size(), 0);
   endtask

   typedef struct {
      logic [511:0] w;
      logic [511:0] a;
      logic [15:0]  exp;
      bit           gaps;
   } vec_t;

   vec_t tbl[5];

   initial begin
      int   base;
      logic [511:0] rw, ra;

      tbl[0].w = {128{4'h1}}; tbl[0].a = {128{4'h1}}; tbl[0].exp = 16'h0080; tbl[0].gaps = 0;
      tbl[1].w = {128{4'h8}}; tbl[1].a = {128{4'h8}}; tbl[1].exp = 16'h2000; tbl[1].gaps = 0;
      tbl[2].w = '0; tbl[2].w[31:0] = 32'h0000_00F1;
      tbl[2].a = '0; tbl[2].a[31:0] = 32'h0000_0003;
      tbl[2].exp = 16'h0003; tbl[2].gaps = 0;
      for (int k = 0; k < 16; k++) begin
         rw[k*32 +: 32] = $urandom;
         ra[k*32 +: 32] = $urandom;
      end
      tbl[3].w = rw; tbl[3].a = ra; tbl[3].exp = dot_model(rw, ra); tbl[3].gaps = 0;
      tbl[4].w = ra; tbl[4].a = rw; tbl[4].exp = dot_model(ra, rw); tbl[4].gaps = 1;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      #2;
      check("rst_s_ready", s_ready, 1);
      check("rst_o_start", o_start, 0);
      check("rst_m_valid", m_valid, 0);
      check("rst_m_data", m_data, 0);
      check("rst_m_err", m_err, 0);
      check("rst_busy", busy, 0);
      check("rst_weights", |o_weights_flat, 0);
      check("rst_acts", |o_acts_flat, 0);
      @(negedge clk);

      // Back-to-back jobs with m_ready held high.
      base = start_cyc.size();
      for (int t = 0; t < 5; t++) begin
         sb.push_back('{d: tbl[t].exp, e: 1'b0});
         run_job(tbl[t].w, tbl[t].a, tbl[t].gaps);
      end
      drain("table_drain");
      for (int t = 1; t < 4; t++) check("job_period", start_cyc[base+t] - start_cyc[base+t-1], 42);

      // Output back-pressure: result held, input blocked, stray done ignored.
      m_ready = 1'b0;
      sb.push_back('{d: 16'h0003, e: 1'b0});
      run_job(tbl[2].w, tbl[2].a, 0);
      begin
         int t = 0;
         while (!m_valid && t < 50) begin
            @(negedge clk);
            t++;
         end
      end
      check("hold_valid_rise", m_valid, 1);
      for (int i = 0; i < 20; i++) begin
         if (i == 5) stray_cnt++;
         @(negedge clk);
         #1;
         check("hold_data", m_data, 16'h0003);
         check("hold_s_ready", s_ready, 0);
         check("hold_valid", m_valid, 1);
      end
      m_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("post_hold_s_ready", s_ready, 1);
      check("post_hold_valid", m_valid, 0);
      check("post_hold_drained", sb.size(), 0);

      // Reset mid weight load discards the partial job.
      for (int k = 0; k < 10; k++) send_beat(32'hFFFF_FFFF, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_valid", m_valid, 0);
      check("midrst_weights", |o_weights_flat, 0);
      sb.push_back('{d: 16'hFC00, e: 1'b0});
      run_job(tbl[0].w, tbl[1].a, 0);
      drain("midrst_drain");

`ifdef DOT_FEEDER_TIMEOUT_EN
      eng_enable = 1'b0;
      sb.push_back('{d: 16'h0000, e: 1'b1});
      run_job(tbl[0].w, tbl[0].a, 0);
      for (int i = 1; i <= 64; i++) @(negedge clk);
      check("tmo_valid_early", m_valid, 0);
      @(negedge clk);
      check("tmo_valid", m_valid, 1);
      check("tmo_err", m_err, 1);
      check("tmo_data", m_data, 0);
      drain("tmo_drain");
      eng_enable = 1'b1;
`endif

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
